// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: state encoding and header geometry shared by the boot image loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  // Stream header is a little-endian byte count.
  localparam int HDR_BYTES = 2;
  localparam int LEN_W     = 16;

  // A non-zero length is loadable when it fits the memory budget and is whole 32-bit words.
  function automatic logic len_ok(input logic [LEN_W-1:0] len, input int max_bytes);
    return (32'(len) <= 32'(max_bytes)) && (len[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// imem_loader: writes a length-prefixed byte stream into instruction memory, holding the core until complete.
// Latency: one cycle from payload accept to mem_we; done/cpu_hold release coincide with the last write.
// Backpressure: in_ready only in header/payload/trailer phases; optional XOR trailer via IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0,
  parameter int MAX_BYTES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [LEN_W-1:0]  bytes_left
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_t                      state, nxt_state;
  logic [8*(HDR_BYTES-1)-1:0]  len_lo, nxt_len_lo;
  logic [ADDR_W-1:0]           ptr, nxt_ptr;
  logic [LEN_W-1:0]            hdr_len;
  logic                        accept;
  logic                        nxt_rdy, nxt_we, nxt_hold, nxt_done, nxt_error;
  logic [ADDR_W-1:0]           nxt_addr;
  logic [7:0]                  nxt_wdata;
  logic [LEN_W-1:0]            nxt_left;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]                  csum, nxt_csum;
`endif

  assign accept  = in_valid && in_ready;
  assign hdr_len = {in_data, len_lo};

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    nxt_state  = state;
    nxt_len_lo = len_lo;
    nxt_ptr    = ptr;
    nxt_we     = 1'b0;
    nxt_addr   = mem_addr;
    nxt_wdata  = mem_wdata;
    nxt_hold   = cpu_hold;
    nxt_done   = done;
    nxt_error  = error;
    nxt_left   = bytes_left;
`ifdef IMEM_LOADER_CHECKSUM_EN
    nxt_csum   = csum;
`endif
    unique case (state)
      S_IDLE: begin
        nxt_hold = 1'b1;
        if (start) nxt_state = S_LEN0;
      end
      S_LEN0: begin
        if (accept) begin
          nxt_len_lo = in_data;
          nxt_state  = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          if (hdr_len == '0) begin
            nxt_state = S_DONE;
            nxt_done  = 1'b1;
            nxt_hold  = 1'b0;
          end else if (!len_ok(hdr_len, MAX_BYTES)) begin
            nxt_state = S_ERROR;
            nxt_error = 1'b1;
          end else begin
            nxt_state = S_DATA;
            nxt_left  = hdr_len;
            nxt_ptr   = BASE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            nxt_csum  = 8'h00;
`endif
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          nxt_we    = 1'b1;
          nxt_addr  = ptr;
          nxt_wdata = in_data;
          nxt_ptr   = ptr + ADDR_W'(1);
          nxt_left  = bytes_left - LEN_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
          nxt_csum  = csum ^ in_data;
          if (bytes_left == LEN_W'(1)) nxt_state = S_CSUM;
`else
          // Release the core in the same cycle the final byte lands.
          if (bytes_left == LEN_W'(1)) begin
            nxt_state = S_DONE;
            nxt_done  = 1'b1;
            nxt_hold  = 1'b0;
          end
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) begin
          if (in_data == csum) begin
            nxt_state = S_DONE;
            nxt_done  = 1'b1;
            nxt_hold  = 1'b0;
          end else begin
            nxt_state = S_ERROR;
            nxt_error = 1'b1;
          end
        end
      end
`endif
      S_DONE: begin
        if (start) begin
          nxt_state = S_LEN0;
          nxt_done  = 1'b0;
          nxt_hold  = 1'b1;
        end
      end
      S_ERROR: begin
        if (start) begin
          nxt_state = S_LEN0;
          nxt_error = 1'b0;
        end
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_hold  = 1'b1;
      end
    endcase
    nxt_rdy = (nxt_state == S_LEN0) || (nxt_state == S_LEN1) ||
              (nxt_state == S_DATA) || (nxt_state == S_CSUM);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      len_lo     <= '0;
      ptr        <= BASE;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE;
      mem_wdata  <= 8'h00;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      bytes_left <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= 8'h00;
`endif
    end else begin
      state      <= nxt_state;
      len_lo     <= nxt_len_lo;
      ptr        <= nxt_ptr;
      in_ready   <= nxt_rdy;
      mem_we     <= nxt_we;
      mem_addr   <= nxt_addr;
      mem_wdata  <= nxt_wdata;
      cpu_hold   <= nxt_hold;
      done       <= nxt_done;
      error      <= nxt_error;
      bytes_left <= nxt_left;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= nxt_csum;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: drives two loaders (base 0 and base 4092) with one shared stream.
// Expected writes are queued at accept time; a negedge monitor pops and compares each mem_we.
// Load outcome is predicted from the length/checksum rules alone.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int AW    = 12;
  localparam int BASE1 = 4092;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, start, in_valid;
  logic [7:0] in_data;
  logic rdy0, we0, hold0, done0, err0, rdy1, we1, hold1, done1, err1;
  logic [AW-1:0] addr0, addr1;
  logic [7:0] wd0, wd1;
  logic [15:0] left0, left1;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(AW), .BASE_ADDR(0), .MAX_BYTES(4096)) u0 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0),
    .cpu_hold(hold0), .done(done0), .error(err0), .bytes_left(left0));

  imem_loader #(.ADDR_W(AW), .BASE_ADDR(BASE1), .MAX_BYTES(4096)) u1 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
    .cpu_hold(hold1), .done(done1), .error(err1), .bytes_left(left1));

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    int            cyc;
    bit            last;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  logic [7:0] mem0 [4096];
  logic [7:0] mem1 [4096];
  logic [7:0] strm[$];
  logic [7:0] pay[$];
  int cyc = 0;
  int last_n = 0;
  int n_chk = 0;
  int n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (we0) begin
      if (q0.size() == 0) chk("u0 spurious mem_we", 32'(we0), 0);
      else begin
        e0 = q0.pop_front();
        chk("u0 addr", 32'(addr0), 32'(e0.addr));
        chk("u0 data", 32'(wd0), 32'(e0.data));
        chk("u0 write cycle", cyc, e0.cyc);
        if (e0.last) begin
          chk("u0 done with last write", 32'(done0), 1);
          chk("u0 hold released with last write", 32'(hold0), 0);
        end
        mem0[addr0] = wd0;
      end
    end
    if (we1) begin
      if (q1.size() == 0) chk("u1 spurious mem_we", 32'(we1), 0);
      else begin
        e1 = q1.pop_front();
        chk("u1 addr", 32'(addr1), 32'(e1.addr));
        chk("u1 data", 32'(wd1), 32'(e1.data));
        chk("u1 write cycle", cyc, e1.cyc);
        mem1[addr1] = wd1;
      end
    end
  end

  // Present one byte after 'gap' idle cycles; queue its expected write if it is payload.
  task automatic send_byte(input logic [7:0] b, input int gap, input int idx, input bit last);
    int n;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    do begin @(negedge clk); n++; end while (!rdy0 && n < 200);
    if (!rdy0) chk("accept timeout", 32'(rdy0), 1);
    else if (idx >= 0) begin
      q0.push_back('{addr: AW'(idx % 4096), data: b, cyc: cyc + 1, last: last});
      q1.push_back('{addr: AW'((BASE1 + idx) % 4096), data: b, cyc: cyc + 1, last: last});
    end
    last_n = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("start: in_ready", 32'(rdy0), 1);
    chk("start: done cleared", 32'(done0), 0);
    chk("start: error cleared", 32'(err0), 0);
    chk("start: cpu_hold", 32'(hold0), 1);
    @(posedge clk); #1;
  endtask

  // One complete load; pay must hold len bytes when len is legal.
  task automatic run_load(input string tag, input logic [15:0] len, input int gap_mode, input logic [7:0] tdelta);
    bit legal, exp_ok, last;
    logic [7:0] x;
    int idx, gap, n;
    pulse_start();
    legal  = (len != 0) && (len <= 4096) && (len % 4 == 0);
    exp_ok = (len == 0) || legal;
    strm   = {};
    strm.push_back(len[7:0]);
    strm.push_back(len[15:8]);
    x = 8'h00;
    if (legal) begin
      for (int i = 0; i < int'(len); i++) begin
        strm.push_back(pay[i]);
        x = x ^ pay[i];
      end
      if (CSUM_EN) begin
        strm.push_back(x ^ tdelta);
        if (tdelta != 8'h00) exp_ok = 1'b0;
      end
    end
    for (int i = 0; i < strm.size(); i++) begin
      idx  = (legal && i >= HDR_BYTES && i < HDR_BYTES + int'(len)) ? i - HDR_BYTES : -1;
      last = legal && !CSUM_EN && (i == HDR_BYTES + int'(len) - 1);
      gap  = (gap_mode == 0) ? 0 : (gap_mode == 1) ? ((i == 0) ? 0 : 3) : $urandom_range(0, 3);
      send_byte(strm[i], gap, idx, last);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!(done0 || err0) && n < 40);
    chk({tag, ": status cycle"}, cyc, last_n + 1);
    chk({tag, ": done"}, 32'(done0), 32'(exp_ok));
    chk({tag, ": error"}, 32'(err0), 32'(!exp_ok));
    chk({tag, ": cpu_hold"}, 32'(hold0), 32'(!exp_ok));
    chk({tag, ": in_ready low"}, 32'(rdy0), 0);
    chk({tag, ": u1 done"}, 32'(done1), 32'(exp_ok));
    chk({tag, ": u1 error"}, 32'(err1), 32'(!exp_ok));
    if (legal) chk({tag, ": bytes_left"}, 32'(left0), 0);
    @(negedge clk);
    chk({tag, ": u0 writes drained"}, q0.size(), 0);
    chk({tag, ": u1 writes drained"}, q1.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] len;
    int kind;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", 32'(rdy0), 0);
    chk("reset mem_we", 32'(we0), 0);
    chk("reset mem_addr", 32'(addr0), 0);
    chk("reset u1 mem_addr", 32'(addr1), 32'h0FFC);
    chk("reset mem_wdata", 32'(wd0), 0);
    chk("reset cpu_hold", 32'(hold0), 1);
    chk("reset done", 32'(done0), 0);
    chk("reset error", 32'(err0), 0);
    chk("reset bytes_left", 32'(left0), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle in_ready", 32'(rdy0), 0);

    pay = {8'h13, 8'h06, 8'h50, 8'h00, 8'h93, 8'h66, 8'hB0, 8'h00};
    run_load("basic", 16'd8, 0, 8'h00);
    chk("basic word0", {mem0[3], mem0[2], mem0[1], mem0[0]}, 32'h00500613);
    chk("wrap word at 4092", {mem1[4095], mem1[4094], mem1[4093], mem1[4092]}, 32'h00500613);
    chk("wrap word at 0", {mem1[3], mem1[2], mem1[1], mem1[0]}, 32'h00B06693);

    run_load("gapped", 16'd8, 1, 8'h00);
    run_load("bad length", 16'd6, 0, 8'h00);
    run_load("recover", 16'd8, 0, 8'h00);
    run_load("zero length", 16'd0, 0, 8'h00);
    run_load("over max", 16'd4100, 0, 8'h00);

    pay = {8'h13, 8'h06, 8'h50, 8'h00};
    run_load("csum trailer 45", 16'd4, 0, 8'h00);
    run_load("csum trailer 44", 16'd4, 0, 8'h01);

    // Reset in the middle of a payload, with an ignored start during DATA.
    pulse_start();
    send_byte(8'h10, 0, -1, 1'b0);
    send_byte(8'h00, 0, -1, 1'b0);
    chk("midload bytes_left", 32'(left0), 16);
    send_byte(8'hA1, 0, 0, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_byte(8'hB2, 1, 1, 1'b0);
    send_byte(8'hC3, 0, 2, 1'b0);
    chk("midload bytes_left after 3", 32'(left0), 13);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midreset in_ready", 32'(rdy0), 0);
    chk("midreset mem_we", 32'(we0), 0);
    chk("midreset cpu_hold", 32'(hold0), 1);
    chk("midreset done", 32'(done0), 0);
    chk("midreset writes drained", q0.size(), 0);
    chk("midreset memory kept", 32'(mem0[2]), 32'h00C3);
    @(posedge clk); #1;

    pay = {};
    for (int i = 0; i < 4096; i++) pay.push_back(8'($urandom));
    run_load("max length", 16'd4096, 0, 8'h00);

    for (int t = 0; t < 10; t++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) len = 16'd0;
      else if (kind == 1) len = 16'(4 * $urandom_range(0, 10) + $urandom_range(1, 3));
      else if (kind == 2) len = 16'(4100 + 4 * $urandom_range(0, 100));
      else len = 16'(4 * $urandom_range(1, 12));
      pay = {};
      for (int i = 0; i < 48; i++) pay.push_back(8'($urandom));
      run_load("random", len, $urandom_range(0, 2),
               ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the byte-addressed instruction memory (4096 x 8, little-endian words, read combinationally by fetch).
- Receives a length-prefixed byte stream over a valid/ready handshake and issues one byte write per accepted payload byte, at incrementing addresses.
- Holds the core in reset (`cpu_hold`) until the image is fully written.
- Sits between the boot byte source (UART/debug bridge) and the instruction memory write port.

Parameters:
- ADDR_W, 12, byte address width of instruction memory
- BASE_ADDR, 0, first byte address written
- MAX_BYTES, 4096, largest legal payload length in bytes

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR
- in_valid  in  1  source has a byte on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts in_data this cycle
- mem_we  out  1  byte write strobe to instruction memory
- mem_addr  out  ADDR_W  byte write address
- mem_wdata  out  8  byte write data
- cpu_hold  out  1  keeps core/PC in reset while high
- done  out  1  load finished successfully
- error  out  1  load aborted
- bytes_left  out  16  payload bytes still expected

Behaviour:
- Clock and reset: one clock, `clk`. `reset` is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=1, done=0, error=0, bytes_left=0.
- Handshake: a byte transfers on a cycle where in_valid and in_ready are both 1. in_ready is 1 only in LEN0, LEN1 and DATA (and CSUM when enabled).
- States:
  - IDLE: start -> LEN0; cpu_hold=1.
  - LEN0: accept -> store low length byte -> LEN1.
  - LEN1: accept -> len = {byte, low}.
    - len == 0 -> DONE.
    - len > MAX_BYTES, or len[1:0] != 0 -> ERROR.
    - otherwise bytes_left=len, ptr=BASE_ADDR -> DATA.
  - DATA: each accept -> next cycle mem_we=1, mem_addr=ptr, mem_wdata=byte; ptr+=1; bytes_left-=1.
    - Acceptance of the last byte -> DONE (or CSUM).
  - DONE: done=1, cpu_hold=0, in_ready=0. start -> clears done, sets cpu_hold=1 -> LEN0.
  - ERROR: error=1, cpu_hold=1. start -> clears error -> LEN0.
- Write strobe and latency:
  - mem_we is a single-cycle pulse, exactly one per accepted payload byte.
  - Latency is 1 cycle from accept to write; back-to-back accepts give back-to-back writes.
- Addressing:
  - Address arithmetic is modulo 2^ADDR_W. BASE_ADDR + len beyond 2^ADDR_W wraps to 0; no error is raised.
- Timing of the final write and cpu_hold release:
  - The last byte's write occurs in the same cycle that done rises.
  - cpu_hold falls that cycle, so the core's first fetch sees the full image on the following cycle.
- Boundary cases:
  - in_valid gaps stall the FSM with no writes.
  - start while in LEN0/LEN1/DATA/CSUM is ignored.
  - in_valid in IDLE/DONE/ERROR is not accepted.
  - reset mid-load: next cycle state=IDLE, mem_we=0, cpu_hold=1. Partially written memory is not cleared.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR of all payload bytes is kept.
  - After the last payload byte the FSM enters CSUM and accepts one trailing byte.
  - Match -> DONE; mismatch -> ERROR (data already written stays written).
- Undefined: no CSUM state and no trailing byte; the stream ends at the last payload byte.

Decomposition:
- Package imem_loader_pkg holds:
  - state enum (IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERROR);
  - HDR_BYTES=2;
  - LEN_W=16.
- Single flat module; no sub-module is warranted.

Test Plan:
- Basic load: start; stream 08 00 13 06 50 00 93 66 B0 00 with in_valid held.
  - Writes at addr 0..7 with data 13,06,50,00,93,66,B0,00 on consecutive cycles.
  - done=1 and cpu_hold=0 in the cycle of the write to addr 7.
  - Memory word 0 reads 0x00500613.
- Gapped valid: same stream with in_valid low for 3 cycles between every byte.
  - Identical writes, each exactly 1 cycle after its accept.
  - No mem_we during gaps.
- Bad length: header 06 00 -> error=1, cpu_hold=1, no mem_we. Then start plus a valid header -> error clears and the load proceeds.
- Zero length and wrap:
  - Header 00 00 -> done on the cycle after LEN1 accept, no writes.
  - With BASE_ADDR=4092, len=8 -> addresses 4092..4095, 0..3.
- Reset mid-load: reset after 3 payload bytes -> next cycle IDLE, cpu_hold=1, done=0, mem_we=0. Ignored start during DATA is also checked.
- IMEM_LOADER_CHECKSUM_EN:
  - Payload 13 06 50 00 with trailer 45 -> done.
  - Same payload with trailer 44 -> error.
